// File: rtl/dispense_sequencer.sv
// Coffee dispense sequencer: accepts one drink order at a time and steps the
// water, coffee, cream and sugar valves through timed phases.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous active-high reset
//   Order_Valid  order request, accepted when Order_Ready=1
//   Order_Type   00 black, 01 cream, 10 cream+sugar, 11 illegal
//   Order_Ready  high only while idle
//   Abort        cancels a drink while a valve phase is running
//   Water/Coffee/Cream/Sugar  valve enables, at most one high
//   Busy         high whenever a drink sequence is in progress
//   Done         one-cycle pulse in the finish cycle
//   Error        one-cycle pulse after an illegal order is rejected
//   Cup_Count    saturating count of completed drinks
module dispense_sequencer #(
  parameter int unsigned WATER_CYC  = 4,
  parameter int unsigned COFFEE_CYC = 3,
  parameter int unsigned CREAM_CYC  = 2,
  parameter int unsigned SUGAR_CYC  = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Order_Valid,
  input  logic [1:0] Order_Type,
  output logic       Order_Ready,
  input  logic       Abort,
  output logic       Water,
  output logic       Coffee,
  output logic       Cream,
  output logic       Sugar,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [7:0] Cup_Count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CUP_W = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WATER  = 3'd1;
  localparam logic [2:0] S_COFFEE = 3'd2;
  localparam logic [2:0] S_CREAM  = 3'd3;
  localparam logic [2:0] S_SUGAR  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [1:0] T_BLACK   = 2'b00;
  localparam logic [1:0] T_SUGAR   = 2'b10;
  localparam logic [1:0] T_ILLEGAL = 2'b11;

  localparam logic [CNT_W-1:0] WATER_LD  = CNT_W'(WATER_CYC - 1);
  localparam logic [CNT_W-1:0] COFFEE_LD = CNT_W'(COFFEE_CYC - 1);
  localparam logic [CNT_W-1:0] CREAM_LD  = CNT_W'(CREAM_CYC - 1);
  localparam logic [CNT_W-1:0] SUGAR_LD  = CNT_W'(SUGAR_CYC - 1);
  localparam logic [CUP_W-1:0] CUP_MAX   = '1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       type_q, type_d;
  logic [CUP_W-1:0] cup_q, cup_d;
  logic             error_d;

  logic ready_q, water_q, coffee_q, cream_q, sugar_q, busy_q, done_q, error_q;

  logic phase_end;
  assign phase_end = (cnt_q == '0);

  // Next-state, phase counter, latched type and cup counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    cup_d   = cup_q;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Abort is ignored here; an order is still accepted with it
        if (Order_Valid) begin
          type_d = Order_Type;
          if (Order_Type == T_ILLEGAL) begin
            error_d = 1'b1;
          end else begin
            state_d = S_WATER;
            cnt_d   = WATER_LD;
          end
        end
      end
      S_WATER, S_COFFEE, S_CREAM, S_SUGAR: begin
        // Abort wins over a same-cycle phase end
        if (Abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!phase_end) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = '0;
          case (state_q)
            S_WATER: begin
              state_d = S_COFFEE;
              cnt_d   = COFFEE_LD;
            end
            S_COFFEE: begin
              if (type_q == T_BLACK) begin
                state_d = S_FINISH;
              end else begin
                state_d = S_CREAM;
                cnt_d   = CREAM_LD;
              end
            end
            S_CREAM: begin
              if (type_q == T_SUGAR) begin
                state_d = S_SUGAR;
                cnt_d   = SUGAR_LD;
              end else begin
                state_d = S_FINISH;
              end
            end
            default: state_d = S_FINISH;
          endcase
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (cup_q != CUP_MAX) begin
          cup_d = cup_q + CUP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; outputs track the state being entered
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      type_q   <= T_BLACK;
      cup_q    <= '0;
      ready_q  <= 1'b1;
      water_q  <= 1'b0;
      coffee_q <= 1'b0;
      cream_q  <= 1'b0;
      sugar_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      cup_q    <= cup_d;
      ready_q  <= (state_d == S_IDLE);
      water_q  <= (state_d == S_WATER);
      coffee_q <= (state_d == S_COFFEE);
      cream_q  <= (state_d == S_CREAM);
      sugar_q  <= (state_d == S_SUGAR);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_FINISH);
      error_q  <= error_d;
    end
  end

  assign Order_Ready = ready_q;
  assign Water       = water_q;
  assign Coffee      = coffee_q;
  assign Cream       = cream_q;
  assign Sugar       = sugar_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Error       = error_q;
  assign Cup_Count   = cup_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with default phase lengths.
module tb_dispense_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Order_Valid;
  logic [1:0] Order_Type;
  logic       Order_Ready;
  logic       Abort;
  logic       Water, Coffee, Cream, Sugar;
  logic       Busy, Done, Error;
  logic [7:0] Cup_Count;

  int checks = 0;
  int errors = 0;

  dispense_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Order_Valid (Order_Valid),
    .Order_Type  (Order_Type),
    .Order_Ready (Order_Ready),
    .Abort       (Abort),
    .Water       (Water),
    .Coffee      (Coffee),
    .Cream       (Cream),
    .Sugar       (Sugar),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error),
    .Cup_Count   (Cup_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Output vector: {Water, Coffee, Cream, Sugar, Busy, Done, Error, Order_Ready}
  function automatic logic [7:0] obs_vec();
    return {Water, Coffee, Cream, Sugar, Busy, Done, Error, Order_Ready};
  endfunction

  // Expected vector for cycle c after accept, default phase lengths
  function automatic logic [7:0] exp_vec(input logic [1:0] t, input int c);
    int fin;
    logic w, co, cr, su, bz, dn, rd;
    fin = (t == 2'b00) ? 8 : (t == 2'b01) ? 10 : 12;
    w  = (c >= 1) && (c <= 4);
    co = (c >= 5) && (c <= 7);
    cr = (t != 2'b00) && (c >= 8) && (c <= 9);
    su = (t == 2'b10) && (c >= 10) && (c <= 11);
    bz = (c >= 1) && (c <= fin);
    dn = (c == fin);
    rd = !bz;
    return {w, co, cr, su, bz, dn, 1'b0, rd};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one order with a fully checked per-cycle trace
  task automatic run_order(input string name, input logic [1:0] t,
                           input logic [7:0] cup_before, input logic [7:0] cup_after);
    int fin;
    fin = (t == 2'b00) ? 8 : (t == 2'b01) ? 10 : 12;
    Order_Valid = 1'b1;
    Order_Type  = t;
    step();
    Order_Valid = 1'b0;
    Order_Type  = 2'b11;  // later type changes must be ignored
    for (int c = 1; c <= fin + 1; c++) begin
      chk($sformatf("%s_vec_c%0d", name, c), 32'(obs_vec()), 32'(exp_vec(t, c)));
      if (c == fin)
        chk($sformatf("%s_cup_c%0d", name, c), 32'(Cup_Count), 32'(cup_before));
      if (c <= fin) step();
    end
    chk($sformatf("%s_cup_end", name), 32'(Cup_Count), 32'(cup_after));
  endtask

  task automatic run_quiet();
    Order_Valid = 1'b1;
    Order_Type  = 2'b00;
    step();
    Order_Valid = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    Reset       = 1'b1;
    Order_Valid = 1'b0;
    Order_Type  = 2'b00;
    Abort       = 1'b0;
    step();
    step();
    chk("reset_vec", 32'(obs_vec()), 32'(8'b0000_0001));
    chk("reset_cup", 32'(Cup_Count), 32'd0);
    Reset = 1'b0;
    step();
    chk("ready_after_reset", 32'(Order_Ready), 32'd1);

    run_order("black", 2'b00, 8'd0, 8'd1);
    run_order("cream", 2'b01, 8'd1, 8'd2);
    run_order("sugar", 2'b10, 8'd2, 8'd3);

    // Illegal order: Error pulse only
    Order_Valid = 1'b1;
    Order_Type  = 2'b11;
    step();
    Order_Valid = 1'b0;
    chk("illegal_c1", 32'(obs_vec()), 32'(8'b0000_0011));
    step();
    chk("illegal_c2", 32'(obs_vec()), 32'(8'b0000_0001));
    chk("illegal_cup", 32'(Cup_Count), 32'd3);

    // Abort on 2nd coffee cycle with Order_Valid held high throughout
    Order_Valid = 1'b1;
    Order_Type  = 2'b00;
    step();
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("hold_vec_c%0d", c), 32'(obs_vec()), 32'(exp_vec(2'b00, c)));
      if (c == 6) Abort = 1'b1;
      step();
    end
    // Back in IDLE; Abort still high with Valid must still accept
    chk("abort_vec", 32'(obs_vec()), 32'(8'b0000_0001));
    chk("abort_cup", 32'(Cup_Count), 32'd3);
    step();
    Abort       = 1'b0;
    Order_Valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("reaccept_vec_c%0d", c), 32'(obs_vec()), 32'(exp_vec(2'b00, c)));
      if (c <= 8) step();
    end
    chk("reaccept_cup", 32'(Cup_Count), 32'd4);

    // Abort on the last water cycle beats the move to COFFEE
    Order_Valid = 1'b1;
    Order_Type  = 2'b00;
    step();
    Order_Valid = 1'b0;
    step();
    step();
    step();
    chk("abort_last_water_pre", 32'(obs_vec()), 32'(exp_vec(2'b00, 4)));
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("abort_last_water", 32'(obs_vec()), 32'(8'b0000_0001));
    step();
    chk("abort_last_water_idle", 32'(obs_vec()), 32'(8'b0000_0001));

    // Abort in FINISH is ignored
    Order_Valid = 1'b1;
    Order_Type  = 2'b00;
    step();
    Order_Valid = 1'b0;
    repeat (7) step();
    chk("finish_done", 32'(Done), 32'd1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("finish_abort_vec", 32'(obs_vec()), 32'(8'b0000_0001));
    chk("finish_abort_cup", 32'(Cup_Count), 32'd5);

    // Reset during WATER
    Order_Valid = 1'b1;
    Order_Type  = 2'b10;
    step();
    Order_Valid = 1'b0;
    step();
    chk("pre_reset_water", 32'(Water), 32'd1);
    Reset       = 1'b1;
    Abort       = 1'b1;
    Order_Valid = 1'b1;
    step();
    Reset       = 1'b0;
    Abort       = 1'b0;
    Order_Valid = 1'b0;
    chk("midreset_vec", 32'(obs_vec()), 32'(8'b0000_0001));
    chk("midreset_cup", 32'(Cup_Count), 32'd0);
    run_order("post_reset", 2'b00, 8'd0, 8'd1);

    // Saturation at 255
    repeat (254) run_quiet();
    chk("preload_cup", 32'(Cup_Count), 32'd255);
    run_order("saturate", 2'b00, 8'd255, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispense_sequencer.md
DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
  WATER_CYC, 4, Water valve open time in cycles (legal 1..15)
  COFFEE_CYC, 3, Coffee valve open time in cycles (legal 1..15)
  CREAM_CYC, 2, Cream valve open time in cycles (legal 1..15)
  SUGAR_CYC, 2, Sugar valve open time in cycles (legal 1..15)
REQ-002 Ports SHALL be, one per line:
  Clock  input  1  single clock; all logic on rising edge
  Reset  input  1  synchronous, active-high reset
  Order_Valid  input  1  order request
  Order_Type  input  2  00 black, 01 cream, 10 cream+sugar, 11 illegal
  Order_Ready  output  1  order can be accepted
  Abort  input  1  cancel the current drink
  Water, Coffee, Cream, Sugar  output  1 each  valve enables
  Busy  output  1  sequence in progress
  Done  output  1  one-cycle pulse when a drink completes
  Error  output  1  one-cycle pulse when an illegal order is rejected
  Cup_Count  output  8  completed-drink counter
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with the clock port named Clock and the reset port named Reset.

Function
REQ-004 FSM states SHALL be IDLE, WATER, COFFEE, CREAM, SUGAR, FINISH, held in registers.
REQ-005 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.
REQ-006 Order_Ready SHALL be 1 only in IDLE.
REQ-007 Handshake SHALL be: accept on the edge where Order_Valid=1 and Order_Ready=1, latching Order_Type internally; later changes to Order_Type SHALL be ignored.
REQ-008 An accepted type 11 order SHALL keep the FSM in IDLE, pulse Error for exactly one cycle on the next cycle, and drive no valve.
REQ-009 An accepted legal order SHALL go IDLE->WATER on the accept edge.
REQ-010 The sequence SHALL be:
  - WATER for WATER_CYC cycles, then COFFEE for COFFEE_CYC cycles;
  - then CREAM for CREAM_CYC cycles if type is 01 or 10;
  - then SUGAR for SUGAR_CYC cycles if type is 10;
  - then FINISH for exactly 1 cycle, then IDLE.
REQ-011 Each valve output SHALL be 1 exactly while in its matching state, with at most one valve high in any cycle.
REQ-012 Phase timing SHALL use a 4-bit down-counter loaded with (param-1) on state entry; the state SHALL advance on the edge where the count equals 0.
REQ-013 In FINISH, Done SHALL be 1 and Cup_Count SHALL increment by 1 on the FINISH edge, saturating at 255 with no wrap.
REQ-014 Busy SHALL be 1 in every state except IDLE.
REQ-015 Order_Valid SHALL be ignored while Busy=1; there is no queueing and no Error for these requests.
REQ-016 Abort=1 in WATER/COFFEE/CREAM/SUGAR SHALL force IDLE on that edge: valves go 0 the next cycle, with no Done and no Cup_Count change.
REQ-017 Abort SHALL take priority over a same-cycle phase-end transition.
REQ-018 Abort SHALL be ignored in IDLE and FINISH; FINISH always completes.
REQ-019 Abort=1 together with Order_Valid=1 in IDLE SHALL still accept the order.
REQ-020 For a black order with default parameters, cycle 1 after accept SHALL be Water, Coffee 3 cycles, FINISH 1 cycle, and Order_Ready=1 again 9 cycles after accept; total busy is 1+Σphases cycles.

Reset
REQ-021 Reset=1 at a rising edge SHALL set state IDLE, all valves 0, Busy 0, Done 0, Error 0, Cup_Count 0, phase counter 0, latched type 00.
REQ-022 Reset SHALL override Abort, Order_Valid and any mid-sequence state, with no Done pulse.
REQ-023 Order_Ready SHALL be 1 on the first cycle after Reset deasserts.

Verification
REQ-024 Black order with defaults: Order_Valid=1, Type=00 for one cycle -> Water high cycles 1-4, Coffee 5-7, Done 8, Cup_Count 0->1, Order_Ready=1 cycle 9; Cream and Sugar never high.
REQ-025 Cream+sugar order with defaults: Type=10 -> Water 1-4, Coffee 5-7, Cream 8-9, Sugar 10-11, Done 12; exactly one valve high in each cycle.
REQ-026 Illegal order: Type=11 -> Error=1 for one cycle, Busy stays 0, no valve, Cup_Count unchanged.
REQ-027 Abort on the 2nd Coffee cycle of a black order -> next cycle all valves 0, IDLE, Order_Ready=1, no Done, Cup_Count unchanged; Order_Valid held high through the busy period -> exactly one order accepted, the next accepted only in IDLE.
REQ-028 Reset=1 during WATER -> next cycle all outputs at reset values, Cup_Count=0; the next order then runs the full sequence.
REQ-029 Saturation: preload 255 completed drinks, run one more order -> Done pulses and Cup_Count stays 255.
